// File: rtl/alu_arbiter.sv
// Shares one combinational 64-bit ALU between two requesters with per-port 1-entry response buffers.
// Latency: grant in cycle T, response valid in T+1; a port stalls while its buffer is full and not draining.
module alu_arbiter #(
    parameter int TAG_W    = 4,
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [63:0]      r0_SrcA,
    input  logic [63:0]      r0_SrcB,
    input  logic [4:0]       r0_ALUControl,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [63:0]      r1_SrcA,
    input  logic [63:0]      r1_SrcB,
    input  logic [4:0]       r1_ALUControl,
    input  logic [TAG_W-1:0] r1_tag,
    output logic [63:0]      alu_SrcA,
    output logic [63:0]      alu_SrcB,
    output logic [4:0]       alu_ALUControl,
    input  logic [63:0]      alu_ALUResult,
    input  logic             alu_Zero,
    output logic             d0_valid,
    input  logic             d0_ready,
    output logic [63:0]      d0_result,
    output logic             d0_zero,
    output logic [TAG_W-1:0] d0_tag,
    output logic             d1_valid,
    input  logic             d1_ready,
    output logic [63:0]      d1_result,
    output logic             d1_zero,
    output logic [TAG_W-1:0] d1_tag
);

    logic             r_d0_valid, r_d1_valid;
    logic [63:0]      r_d0_result, r_d1_result;
    logic             r_d0_zero, r_d1_zero;
    logic [TAG_W-1:0] r_d0_tag, r_d1_tag;
    logic             r_last_grant;
    logic [3:0]       r_wait_cnt;

    logic w_elig0, w_elig1, w_pick1, w_gnt0, w_gnt1;

    always_comb begin
        w_elig0 = r0_valid && (!r_d0_valid || d0_ready);
        w_elig1 = r1_valid && (!r_d1_valid || d1_ready);
        if (ARB_MODE == 0)
            w_pick1 = (r_wait_cnt == 4'(MAX_WAIT));
        else
            w_pick1 = !r_last_grant;
        w_gnt0 = !reset && w_elig0 && (!w_elig1 || !w_pick1);
        w_gnt1 = !reset && w_elig1 && (!w_elig0 || w_pick1);
    end

    assign r0_ready = w_gnt0;
    assign r1_ready = w_gnt1;

    // Idle ALU inputs are held at zero so the datapath does not toggle.
    always_comb begin
        alu_SrcA       = 64'd0;
        alu_SrcB       = 64'd0;
        alu_ALUControl = 5'd0;
        if (w_gnt0) begin
            alu_SrcA       = r0_SrcA;
            alu_SrcB       = r0_SrcB;
            alu_ALUControl = r0_ALUControl;
        end else if (w_gnt1) begin
            alu_SrcA       = r1_SrcA;
            alu_SrcB       = r1_SrcB;
            alu_ALUControl = r1_ALUControl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0_valid   <= 1'b0;
            r_d0_result  <= 64'd0;
            r_d0_zero    <= 1'b0;
            r_d0_tag     <= '0;
            r_d1_valid   <= 1'b0;
            r_d1_result  <= 64'd0;
            r_d1_zero    <= 1'b0;
            r_d1_tag     <= '0;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= 4'd0;
        end else begin
            if (w_gnt0) begin
                r_d0_valid  <= 1'b1;
                r_d0_result <= alu_ALUResult;
                r_d0_zero   <= alu_Zero;
                r_d0_tag    <= r0_tag;
            end else if (d0_ready) begin
                r_d0_valid  <= 1'b0;
            end

            if (w_gnt1) begin
                r_d1_valid  <= 1'b1;
                r_d1_result <= alu_ALUResult;
                r_d1_zero   <= alu_Zero;
                r_d1_tag    <= r1_tag;
            end else if (d1_ready) begin
                r_d1_valid  <= 1'b0;
            end

            if (w_gnt0)
                r_last_grant <= 1'b0;
            else if (w_gnt1)
                r_last_grant <= 1'b1;

            // Only count starvation caused by port 0, not by a full d1 buffer.
            if (w_gnt1)
                r_wait_cnt <= 4'd0;
            else if (r1_valid && w_elig1 && (r_wait_cnt != 4'(MAX_WAIT)))
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign d0_valid  = r_d0_valid;
    assign d0_result = r_d0_result;
    assign d0_zero   = r_d0_zero;
    assign d0_tag    = r_d0_tag;
    assign d1_valid  = r_d1_valid;
    assign d1_result = r_d1_result;
    assign d1_zero   = r_d1_zero;
    assign d1_tag    = r_d1_tag;

endmodule
